// File: rtl/cosmem_loader.sv
// UART program loader: parses L/R/H commands, writes image bytes to the memory port, replies over TX.
// ld_we fires the cycle after a byte is received; bytes arriving in IDLE while TX is busy are dropped.
module cosmem_loader #(
  parameter int CLKS_PER_BIT  = 139,
  parameter int TIMEOUT_CLKS  = 1600000,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  output logic        txd,
  output logic        ld_we,
  output logic [15:0] ld_addr,
  output logic [7:0]  ld_wdata,
  output logic        hold,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CLKS - 1);

  // ---------------- RX ----------------
  logic rx_meta, rx_sync, rx_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t       rx_st, rx_st_nx;
  logic [CW-1:0]   rx_cnt, rx_cnt_nx;
  logic [2:0]      rx_idx, rx_idx_nx;
  logic [7:0]      rx_data, rx_data_nx;
  logic            rx_valid, rx_valid_nx;
  logic            rx_ferr, rx_ferr_nx;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_st    <= rx_st_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_idx   <= rx_idx_nx;
      rx_data  <= rx_data_nx;
      rx_valid <= rx_valid_nx;
      rx_ferr  <= rx_ferr_nx;
    end
  end

  always_comb begin
    rx_st_nx    = rx_st;
    rx_cnt_nx   = rx_cnt + CW'(1);
    rx_idx_nx   = rx_idx;
    rx_data_nx  = rx_data;
    rx_valid_nx = 1'b0;
    rx_ferr_nx  = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_last && !rx_sync) rx_st_nx = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch
        if (rx_cnt == HALF_END) begin
          rx_cnt_nx = '0;
          rx_idx_nx = '0;
          rx_st_nx  = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_nx  = '0;
          rx_data_nx = {rx_sync, rx_data[7:1]};
          rx_idx_nx  = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_st_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_st_nx    = RX_IDLE;
          rx_valid_nx = rx_sync;
          rx_ferr_nx  = !rx_sync;
        end
      end
      default: rx_st_nx = RX_IDLE;
    endcase
  end

  // ---------------- TX ----------------
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy;
  logic [8:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_bit  <= '0;
      tx_cnt  <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        txd     <= 1'b0;
        tx_sh   <= {1'b1, tx_byte};
        tx_bit  <= '0;
        tx_cnt  <= '0;
        tx_busy <= 1'b1;
      end
    end else if (tx_cnt == BIT_END) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        txd    <= tx_sh[0];
        tx_sh  <= {1'b1, tx_sh[8:1]};
        tx_bit <= tx_bit + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // ---------------- Command FSM ----------------
  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, REPLY} state_t;
  state_t        state, state_nx;
  logic [15:0]   addr;
  logic [7:0]    len_h;
  logic [15:0]   remain;
  logic [7:0]    csum;
  logic [TW-1:0] to_cnt;
  logic          in_load, timeout, cmd_ok;

  assign in_load = (state == ADDR_H) || (state == ADDR_L) || (state == LEN_H) ||
                   (state == LEN_L) || (state == DATA);
  assign timeout = in_load && !rx_valid && (to_cnt == TO_END);
  assign cmd_ok  = rx_valid && !tx_busy;
  assign busy    = (state != IDLE) || tx_busy;

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    case (state)
      IDLE: begin
        if (cmd_ok) begin
          case (rx_data)
            8'h4C: state_nx = ADDR_H;
            8'h52, 8'h48: begin
              tx_start = 1'b1;
              tx_byte  = rx_data;
            end
            default: ;
          endcase
        end
      end
      ADDR_H: if (rx_valid) state_nx = ADDR_L;
      ADDR_L: if (rx_valid) state_nx = LEN_H;
      LEN_H:  if (rx_valid) state_nx = LEN_L;
      LEN_L:  if (rx_valid) state_nx = ({len_h, rx_data} == 16'h0000) ? REPLY : DATA;
      DATA:   if (rx_valid && remain == 16'd1) state_nx = REPLY;
      REPLY: begin
        tx_start = 1'b1;
        tx_byte  = csum;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (in_load && (rx_ferr || timeout)) begin
      state_nx = IDLE;
      tx_start = 1'b1;
      tx_byte  = 8'h3F;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      hold     <= HOLD_AT_RESET;
      ld_we    <= 1'b0;
      ld_addr  <= '0;
      ld_wdata <= '0;
      addr     <= '0;
      len_h    <= '0;
      remain   <= '0;
      csum     <= '0;
      to_cnt   <= '0;
    end else begin
      state  <= state_nx;
      ld_we  <= 1'b0;
      to_cnt <= (in_load && !rx_valid) ? to_cnt + TW'(1) : '0;
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (!tx_busy) begin
              if (rx_data == 8'h4C) begin
                hold <= 1'b1;
                csum <= '0;
              end else if (rx_data == 8'h52) begin
                hold <= 1'b0;
              end else if (rx_data == 8'h48) begin
                hold <= 1'b1;
              end
            end
          end
          ADDR_H: addr[15:8] <= rx_data;
          ADDR_L: addr[7:0]  <= rx_data;
          LEN_H:  len_h      <= rx_data;
          LEN_L:  remain     <= {len_h, rx_data};
          DATA: begin
            ld_we    <= 1'b1;
            ld_addr  <= addr;
            ld_wdata <= rx_data;
            addr     <= addr + 16'd1;
            csum     <= csum + rx_data;
            remain   <= remain - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cosmem_loader.md
# cosmem_loader

Serial program loader placed directly upstream of the 1802 memory emulator. It receives a binary image over a UART (8N1), writes it byte-by-byte into the emulator's memory through a dedicated write port, and holds the CPU in reset while loading. It returns an 8-bit checksum when a load completes. Commands from the host release or re-assert CPU reset.

## Interface
- CLKS_PER_BIT, 139, clk cycles per UART bit (16 MHz / 115200).
- TIMEOUT_CLKS, 1600000, maximum clk cycles between bytes inside a command (100 ms).
- HOLD_AT_RESET, 1, value of hold after reset (1 = CPU stays in reset until 'R').

Ports:
- clk  in  1  system clock, 16 MHz.
- resetn  in  1  reset, synchronous, active-low.
- rxd  in  1  UART receive, asynchronous, idle high.
- txd  out  1  UART transmit, idle high.
- ld_we  out  1  one-cycle write strobe to the memory write port.
- ld_addr  out  16  write address; the memory decodes the low bits it implements.
- ld_wdata  out  8  write data, valid while ld_we=1.
- hold  out  1  1 = keep the CPU in reset; this drives the emulator's resetn through an inverter.
- busy  out  1  1 while the command FSM is not IDLE or the TX is active.

## Operation
- **RX path**
  - rxd passes through a 2-flop synchronizer.
  - A high-to-low edge in idle starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2. If it reads high, the frame is aborted silently.
  - The 8 data bits are sampled LSB first at bit midpoints.
  - If the stop bit is 0, the frame is a framing error and the byte is discarded.
  - A good frame produces an internal rx_valid pulse for one cycle.
- **TX path**: 8N1, LSB first, one byte at a time, 10*CLKS_PER_BIT cycles per frame.
- **Command FSM states**: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, REPLY.
- **IDLE**
  - 0x4C 'L': hold<=1, go to ADDR_H.
  - 0x52 'R': hold<=0, transmit 0x52.
  - 0x48 'H': hold<=1, transmit 0x48.
  - Any other byte is ignored, with no reply.
  - Bytes arriving while TX is active are dropped.
- **Load sequence**
  - ADDR_H, ADDR_L, LEN_H and LEN_L each capture one byte, big-endian, forming a 16-bit base address and a 16-bit length.
  - If len=0 after LEN_L, go straight to REPLY with checksum 0x00.
  - In DATA, each byte produces one ld_we pulse with ld_addr=base+i (16-bit, wraps 0xFFFF->0x0000) and ld_wdata=byte.
  - The checksum accumulates sum mod 256 of the data bytes.
  - After byte len-1, go to REPLY.
- **REPLY**: transmit the checksum, then return to IDLE. hold remains 1 after a load.
- **Errors**: an inter-byte timeout (TIMEOUT_CLKS with no rx_valid in ADDR_H..DATA) or a framing error in ADDR_H..DATA aborts to IDLE and transmits 0x3F '?'. Bytes already written stay written. hold stays 1.
- **Reset** (any time, including mid-frame or mid-load): FSM to IDLE, RX/TX idle, hold=HOLD_AT_RESET, txd=1, ld_we=0, ld_addr=0x0000, ld_wdata=0x00, busy=0, checksum cleared.

## Timing
- rx_valid occurs 1 cycle after the stop-bit midpoint sample.
- ld_we is high exactly on the cycle after rx_valid. ld_addr and ld_wdata are registered, and stable from that cycle until the next write.
- The checksum increment and address increment take effect on the ld_we cycle.
- hold changes on the cycle after rx_valid of 'L', 'R' or 'H'.
- txd start bit begins the cycle after the FSM enters REPLY, or the cycle after rx_valid for 'R'/'H'.
- The timeout counter clears on every rx_valid and on entering ADDR_H. Abort happens on the cycle the count reaches TIMEOUT_CLKS-1.
- Minimum write spacing equals one UART frame, so the memory port never sees back-to-back strobes.

## Test plan
- Reset, then idle 100 cycles -> hold=1, txd=1, ld_we=0, busy=0. With HOLD_AT_RESET=0 -> hold=0.
- CLKS_PER_BIT=16; send 4C 01 00 00 03 AA 55 01 -> three ld_we pulses at 0x0100/AA, 0x0101/55, 0x0102/01; TX byte 0x00; hold=1.
- Send 4C FF FF 00 02 10 20 -> writes 0xFFFF/10 then 0x0000/20; TX 0x30.
- Send 4C 00 00 00 00 -> no ld_we; TX 0x00. Then 52 -> hold falls; TX 0x52. Then 48 -> hold=1; TX 0x48.
- Send 4C 00 10 00 05 11, then silence with TIMEOUT_CLKS=2000 -> one write (0x0010/11); TX 0x3F; FSM IDLE; next 'R' is accepted.
- Mid-load frame with stop bit 0 -> no ld_we for it; TX 0x3F. Separately, assert resetn=0 mid-DATA -> all outputs return to reset values next cycle, and a following full load succeeds.
